// File: rtl/hex_display_scan_if.sv
// Value/enable in, segment/anode drive out for the 4-digit hex scanner.
// The source side (counter or bench) uses master; the scanner uses slave.
interface hex_display_scan_if;
  logic [15:0] value;
  logic        enable;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  modport master (
    output value,
    output enable,
    input  seg,
    input  an,
    input  frame_start
  );

  modport slave (
    input  value,
    input  enable,
    output seg,
    output an,
    output frame_start
  );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed 4-digit hex display driver with per-frame value capture,
// one dark cycle per digit slot and optional leading-zero blanking.
module hex_display_scan #(
  parameter int TICK_DIV     = 1000,
  parameter int COMMON_ANODE = 1,
  parameter int BLANK_LZ     = 0
) (
  input logic              clk,
  input logic              rst,
  hex_display_scan_if.slave bus
);

  localparam int           CW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST   = CW'(TICK_DIV - 1);
  localparam logic [6:0]   SEG_OFF = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0]   AN_OFF  = (COMMON_ANODE != 0) ? 4'hF : 4'h0;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          frame_start_q, frame_start_d;

  logic [3:0]    nibble;
  logic          upperZero;
  logic [6:0]    segRaw;
  logic [3:0]    anRaw;

  function automatic logic [6:0] hexCode(input logic [3:0] n);
    logic [6:0] c;
    c = 7'b0000000;
    unique case (n)
      4'h0: c = 7'b0111111;
      4'h1: c = 7'b0000110;
      4'h2: c = 7'b1011011;
      4'h3: c = 7'b1001111;
      4'h4: c = 7'b1100110;
      4'h5: c = 7'b1101101;
      4'h6: c = 7'b1111101;
      4'h7: c = 7'b0000111;
      4'h8: c = 7'b1111111;
      4'h9: c = 7'b1101111;
      4'hA: c = 7'b1110111;
      4'hB: c = 7'b1111100;
      4'hC: c = 7'b0111001;
      4'hD: c = 7'b1011110;
      4'hE: c = 7'b1111001;
      4'hF: c = 7'b1110001;
    endcase
    return c;
  endfunction

  // Digit 0 never blanks; higher digits blank only while everything above is zero.
  always_comb begin
    nibble    = shadow_q[3:0];
    upperZero = 1'b0;
    unique case (digit_q)
      2'd0: begin
        nibble    = shadow_q[3:0];
        upperZero = 1'b0;
      end
      2'd1: begin
        nibble    = shadow_q[7:4];
        upperZero = (shadow_q[15:4] == 12'd0);
      end
      2'd2: begin
        nibble    = shadow_q[11:8];
        upperZero = (shadow_q[15:8] == 8'd0);
      end
      2'd3: begin
        nibble    = shadow_q[15:12];
        upperZero = (shadow_q[15:12] == 4'd0);
      end
    endcase
    segRaw = ((BLANK_LZ != 0) && upperZero) ? 7'b0000000 : hexCode(nibble);
    anRaw  = 4'b0001 << digit_q;
  end

  always_comb begin
    div_cnt_d     = div_cnt_q;
    digit_d       = digit_q;
    shadow_d      = shadow_q;
    frame_start_d = 1'b0;
    seg_d         = SEG_OFF;
    an_d          = AN_OFF;
    if (bus.enable) begin
      if (div_cnt_q == '0 && digit_q == 2'd0) begin
        shadow_d      = bus.value;
        frame_start_d = 1'b1;
      end
      if (div_cnt_q == LAST) begin
        div_cnt_d = '0;
        digit_d   = digit_q + 2'd1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
      // Slot offset 0 stays dark so the previous digit's pattern never ghosts.
      if (div_cnt_q != '0) begin
        an_d  = (COMMON_ANODE != 0) ? ~anRaw : anRaw;
        seg_d = (COMMON_ANODE != 0) ? ~segRaw : segRaw;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      digit_q       <= 2'd0;
      shadow_q      <= 16'd0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_q       <= digit_d;
      shadow_q      <= shadow_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: three parameter variants share one stimulus and
// are compared every cycle against a phase-based frame model.
module tb_hex_display_scan;
  localparam int TICK = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nChecks = 0;
  int   nFails = 0;
  int   edgeCnt = 0;
  bit   checkOn = 1'b0;

  hex_display_scan_if ifc0 ();
  hex_display_scan_if ifc1 ();
  hex_display_scan_if ifc2 ();

  hex_display_scan #(.TICK_DIV(TICK), .COMMON_ANODE(1), .BLANK_LZ(0))
    u0 (.clk(clk), .rst(rst), .bus(ifc0));
  hex_display_scan #(.TICK_DIV(TICK), .COMMON_ANODE(1), .BLANK_LZ(1))
    u1 (.clk(clk), .rst(rst), .bus(ifc1));
  hex_display_scan #(.TICK_DIV(TICK), .COMMON_ANODE(0), .BLANK_LZ(0))
    u2 (.clk(clk), .rst(rst), .bus(ifc2));

  always #5 clk = ~clk;

  localparam logic [6:0] HEX [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  int          mPhase = 0;
  int          mDigit = 0;
  bit          mLit = 1'b0;
  bit          mFs = 1'b0;
  logic [15:0] mShadow = 16'd0;

  // Model: a frame is 4*TICK enabled cycles; phase 0 loads, each slot's first cycle is dark.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase  = 0;
      mShadow = 16'd0;
      mLit    = 1'b0;
      mFs     = 1'b0;
      mDigit  = 0;
      edgeCnt = 0;
    end else begin
      edgeCnt++;
      if (ifc0.enable) begin
        mFs = (mPhase == 0);
        if (mPhase == 0) mShadow = ifc0.value;
        mDigit = mPhase / TICK;
        mLit   = (mPhase % TICK) != 0;
        mPhase = (mPhase + 1) % (4 * TICK);
      end else begin
        mLit = 1'b0;
        mFs  = 1'b0;
      end
    end
  end

  function automatic logic [6:0] expSeg(input bit ca, input bit blz);
    logic [6:0] raw;
    raw = 7'b0000000;
    if (mLit && !(blz && mDigit != 0 && (mShadow >> (4 * mDigit)) == 16'd0))
      raw = HEX[mShadow[4*mDigit +: 4]];
    return ca ? ~raw : raw;
  endfunction

  function automatic logic [3:0] expAn(input bit ca);
    logic [3:0] raw;
    raw = mLit ? (4'b0001 << mDigit) : 4'b0000;
    return ca ? ~raw : raw;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic en);
    ifc0.value = v;  ifc0.enable = en;
    ifc1.value = v;  ifc1.enable = en;
    ifc2.value = v;  ifc2.enable = en;
  endtask

  task automatic waitEdge(input int n);
    int guard;
    guard = 0;
    while (edgeCnt < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("edgeSync", edgeCnt[15:0], n[15:0]);
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("seg0", ifc0.seg, expSeg(1'b1, 1'b0));
      checkOutput("an0",  ifc0.an,  expAn(1'b1));
      checkOutput("fs0",  ifc0.frame_start, mFs);
      checkOutput("seg1", ifc1.seg, expSeg(1'b1, 1'b1));
      checkOutput("an1",  ifc1.an,  expAn(1'b1));
      checkOutput("fs1",  ifc1.frame_start, mFs);
      checkOutput("seg2", ifc2.seg, expSeg(1'b0, 1'b0));
      checkOutput("an2",  ifc2.an,  expAn(1'b0));
      checkOutput("fs2",  ifc2.frame_start, mFs);
    end
  end

  initial begin
    applyStimulus(16'h1234, 1'b1);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOn = 1'b1;
    checkOutput("rstAn",  ifc0.an, 4'b1111);
    checkOutput("rstSeg", ifc0.seg, 7'b1111111);
    checkOutput("rstFs",  ifc0.frame_start, 1'b0);
    rst = 1'b0;

    waitEdge(1);
    checkOutput("e1Fs", ifc0.frame_start, 1'b1);
    checkOutput("e1An", ifc0.an, 4'b1111);
    waitEdge(2);
    checkOutput("e2An",  ifc0.an, 4'b1110);
    checkOutput("e2Seg", ifc0.seg, 7'b0011001);
    waitEdge(4);
    checkOutput("e4Seg", ifc0.seg, 7'b0011001);
    waitEdge(5);
    checkOutput("e5An", ifc0.an, 4'b1111);
    waitEdge(6);
    checkOutput("e6An",  ifc0.an, 4'b1101);
    checkOutput("e6Seg", ifc0.seg, 7'b0110000);

    // New value lands mid-frame; digits 2 and 3 must still show the old capture.
    applyStimulus(16'hABCD, 1'b1);
    waitEdge(10);
    checkOutput("e10An",  ifc0.an, 4'b1011);
    checkOutput("e10Seg", ifc0.seg, 7'b0100100);
    waitEdge(14);
    checkOutput("e14An",  ifc0.an, 4'b0111);
    checkOutput("e14Seg", ifc0.seg, 7'b1111001);
    waitEdge(17);
    checkOutput("e17Fs", ifc0.frame_start, 1'b1);
    waitEdge(18);
    checkOutput("e18Seg",   ifc0.seg, 7'b0100001);
    checkOutput("e18SegHi", ifc2.seg, 7'b1011110);
    checkOutput("e18AnHi",  ifc2.an, 4'b0001);

    waitEdge(26);
    checkOutput("e26Seg", ifc0.seg, 7'b0000011);
    applyStimulus(16'hABCD, 1'b0);
    waitEdge(27);
    checkOutput("offAn", ifc0.an, 4'b1111);
    checkOutput("offFs", ifc0.frame_start, 1'b0);
    waitEdge(31);
    applyStimulus(16'hABCD, 1'b1);
    waitEdge(32);
    checkOutput("resAn",  ifc0.an, 4'b1011);
    checkOutput("resSeg", ifc0.seg, 7'b0000011);
    waitEdge(34);
    checkOutput("resDark", ifc0.an, 4'b1111);
    waitEdge(35);
    checkOutput("resD3An",  ifc0.an, 4'b0111);
    checkOutput("resD3Seg", ifc0.seg, 7'b0001000);

    // Asynchronous reset between edges, then a fresh capture for blanking checks.
    applyStimulus(16'h0050, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arstAn0",  ifc0.an, 4'b1111);
    checkOutput("arstSeg0", ifc0.seg, 7'b1111111);
    checkOutput("arstAn2",  ifc2.an, 4'b0000);
    checkOutput("arstSeg2", ifc2.seg, 7'b0000000);
    @(negedge clk);
    rst = 1'b0;
    waitEdge(1);
    checkOutput("arFs", ifc1.frame_start, 1'b1);
    waitEdge(2);
    checkOutput("lzD0", ifc1.seg, 7'b1000000);
    waitEdge(6);
    checkOutput("lzD1", ifc1.seg, 7'b0010010);
    waitEdge(10);
    checkOutput("lzD2",   ifc1.seg, 7'b1111111);
    checkOutput("lzD2An", ifc1.an, 4'b1011);
    checkOutput("noLzD2", ifc0.seg, 7'b1000000);
    waitEdge(14);
    checkOutput("lzD3", ifc1.seg, 7'b1111111);
    applyStimulus(16'h0000, 1'b1);
    waitEdge(18);
    checkOutput("zD0", ifc1.seg, 7'b1000000);
    waitEdge(22);
    checkOutput("zD1", ifc1.seg, 7'b1111111);

    // Active-high variant fed with counter16 extremes.
    applyStimulus(16'hFFFF, 1'b1);
    waitEdge(34);
    checkOutput("ffSeg", ifc2.seg, 7'b1110001);
    checkOutput("ffAn",  ifc2.an, 4'b0001);
    waitEdge(46);
    checkOutput("ffSeg3", ifc2.seg, 7'b1110001);
    checkOutput("ffAn3",  ifc2.an, 4'b1000);
    applyStimulus(16'h0000, 1'b1);
    waitEdge(50);
    checkOutput("zSegHi", ifc2.seg, 7'b0111111);
    checkOutput("zAnHi",  ifc2.an, 4'b0001);

    repeat (2) @(negedge clk);
    checkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
